bcd_7seg_mux: RTL and testbench
===============================

// Module: bcd_7seg_mux
// PURPOSE
//   Display stage downstream of tt_um_bcd_counter.
//   - Captures NUM_DIGITS packed BCD digits into a pending register on load.
//   - Time-multiplexes the digits onto one shared 7-segment bus, one digit slot at a time.
//   - Inserts one dead (all-off) cycle at each slot change to prevent ghosting.
//   - Takes new values at frame boundaries only, so a frame never mixes old and new digits.
// PARAMETERS
//   NUM_DIGITS   2     number of multiplexed digits (1..8)
//   REFRESH_DIV  1000  clocks per digit slot including the dead cycle (>=2)
//   COMMON_ANODE 0     0: seg/digit_sel active-high; 1: both active-low
//   BLANK_ZEROS  1     1: leading-zero blanking enabled
// PORTS
//   clk        in   1              system clock
//   rst_n      in   1              asynchronous active-low reset
//   ena        in   1              advance enable; 0 freezes the refresh counter and outputs
//   load       in   1              capture bcd_in into the pending register (independent of ena)
//   bcd_in     in   4*NUM_DIGITS   packed digits; [3:0] = digit 0 (units)
//   seg        out  7              {g,f,e,d,c,b,a}
//   digit_sel  out  NUM_DIGITS     one-hot digit enable; bit i drives digit i
//   frame_done out  1              1-cycle pulse after the last slot of a frame completes
// BEHAVIOUR
//   Reset (asynchronous, async-assert):
//     - cnt=0, idx=0; pending, disp and pend_valid cleared.
//     - seg=all off, digit_sel=all inactive (polarity per COMMON_ANODE), frame_done=0.
//   Refresh counter:
//     - If ena=1, cnt increments 0..REFRESH_DIV-1.
//     - At terminal count: cnt<=0, idx<=idx+1, wrapping NUM_DIGITS-1 -> 0.
//     - If ena=0, cnt, idx and all outputs hold.
//   Slot timing:
//     - cnt==0 is the dead cycle.
//     - cnt 1..REFRESH_DIV-1 drive digit idx.
//     - Outputs are registered: values in cycle t+1 reflect cnt/idx in cycle t.
//     - Dead cycle: seg off and digit_sel all inactive.
//   Frame boundary: idx==NUM_DIGITS-1, cnt==REFRESH_DIV-1, ena=1.
//     - If pend_valid: disp<=pending and pend_valid<=0.
//     - frame_done=1 for the following cycle only.
//   Load:
//     - pending<=bcd_in and pend_valid<=1.
//     - If load coincides with the frame boundary, bcd_in bypasses straight to disp
//       and pend_valid stays 0.
//     - Back-to-back loads within one frame: last one wins.
//   Decode:
//     - 0-9: standard segments, e.g. 0=7'h3F, 1=7'h06, 8=7'h7F.
//     - 10-15: 'E' pattern 7'h79.
//   Blanking (BLANK_ZEROS=1):
//     - Digit i>0 is blanked (seg off, digit_sel still active) if disp digit i and all
//       higher digits are 0.
//     - Digit 0 is never blanked.
//   Polarity: COMMON_ANODE=1 bitwise-inverts seg and digit_sel after all logic,
//     including the reset and dead-cycle values.
//   Reset mid-frame: immediate return to reset state; pending load is discarded.
// TESTING  (NUM_DIGITS=2, REFRESH_DIV=4, COMMON_ANODE=0, BLANK_ZEROS=1)
//   1. Reset, ena=1, no load -> dead cycle, then digit_sel=01 seg=3F for 3 cycles;
//      digit 1 blanked (digit_sel=10, seg=00); frame_done every 8 cycles.
//   2. load 8'h47 mid-frame -> display unchanged until frame_done;
//      next frame: digit 0 seg=07, digit 1 seg=66.
//   3. load 8'h05 coincident with boundary -> next frame shows 5 (seg=6D) with digit 1
//      blanked; pend_valid=0.
//   4. ena=0 for 10 cycles mid-slot -> seg, digit_sel and cnt frozen; resumes exactly
//      where stopped.
//   5. load 8'hA0 -> digit 1 shows 79, digit 0 shows 3F (not blanked since digit 1 != 0).
//   6. Assert rst_n=0 mid-slot after a pending load -> outputs off at once;
//      after release the display shows 0, not the pending value.

Source files
------------

// File: rtl/bcd_7seg_mux.sv
// Time-multiplexed BCD to 7-segment display driver with a dead cycle between
// digit slots, frame-synchronous value updates and leading-zero blanking.
module bcd_7seg_mux #(
  parameter int NUM_DIGITS   = 2,
  parameter int REFRESH_DIV  = 1000,
  parameter int COMMON_ANODE = 0,
  parameter int BLANK_ZEROS  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h79;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic                    frame_done_q, frame_done_d;

  logic [6:0]            digit_seg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] slot_sel;
  logic [NUM_DIGITS:1]   upper_zero;
  logic                  boundary;

  // upper_zero[i]: displayed digit i and every digit above it are zero.
  assign upper_zero[NUM_DIGITS] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign slot_sel[gi] = (idx_q == IDX_W'(gi));
      if (gi == 0) begin : g_units
        assign digit_seg[gi] = decode(disp_q[3:0]);
      end else begin : g_upper
        if (gi < NUM_DIGITS - 1) begin : g_mid
          assign upper_zero[gi] = (disp_q[4*gi +: 4] == 4'd0) && upper_zero[gi+1];
        end else begin : g_top
          assign upper_zero[gi] = (disp_q[4*gi +: 4] == 4'd0);
        end
        assign digit_seg[gi] = ((BLANK_ZEROS != 0) && upper_zero[gi]) ? 7'h00
                                                                        : decode(disp_q[4*gi +: 4]);
      end
    end
  endgenerate

  assign boundary = ena && (idx_q == IDX_LAST) && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    pending_d    = pending_q;
    disp_d       = disp_q;
    pend_valid_d = pend_valid_q;
    seg_d        = seg_q;
    sel_d        = sel_q;
    frame_done_d = boundary;

    if (ena) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      // cnt==0 is the anti-ghosting dead cycle of each slot.
      if (cnt_q == '0) begin
        seg_d = '0;
        sel_d = '0;
      end else begin
        seg_d = digit_seg[idx_q];
        sel_d = slot_sel;
      end
    end

    if (load) begin
      pending_d    = bcd_in;
      pend_valid_d = 1'b1;
    end

    // A load landing exactly on the boundary goes straight to the display.
    if (boundary) begin
      if (load) begin
        disp_d       = bcd_in;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        disp_d       = pending_q;
        pend_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pending_q    <= '0;
      disp_q       <= '0;
      pend_valid_q <= 1'b0;
      seg_q        <= '0;
      sel_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      disp_q       <= disp_d;
      pend_valid_q <= pend_valid_d;
      seg_q        <= seg_d;
      sel_q        <= sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Polarity inversion sits after everything, so reset and dead cycles are "off" too.
  assign seg        = (COMMON_ANODE != 0) ? ~seg_q : seg_q;
  assign digit_sel  = (COMMON_ANODE != 0) ? ~sel_q : sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_7seg_mux.sv
// Bench for bcd_7seg_mux (2 digits, 4 clocks per slot): vector table, directed
// corner sequences and random traffic against a frame-level reference model.
module tb_bcd_7seg_mux;

  localparam int ND    = 2;
  localparam int RD    = 4;
  localparam int FRAME = ND * RD;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          load;
  logic [7:0]    bcd_in;
  logic [6:0]    seg;
  logic [1:0]    digit_sel;
  logic          frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_7seg_mux #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .COMMON_ANODE(0),
    .BLANK_ZEROS (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .load      (load),
    .bcd_in    (bcd_in),
    .seg       (seg),
    .digit_sel (digit_sel),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Reference model: position in the frame is just the count of enabled clocks.
  int         m_n;
  logic [7:0] m_disp, m_pend;
  bit         m_pv;
  logic [6:0] e_seg;
  logic [1:0] e_sel;
  logic       e_fd;

  function automatic logic [6:0] ref_seg(input logic [7:0] disp, input int slot);
    int upper;
    int d;
    upper = int'(disp) >> (4 * slot);
    d     = upper % 16;
    if (slot > 0 && upper == 0) return 7'h00;
    return (d > 9) ? 7'h79 : pat[d];
  endfunction

  task automatic model_reset();
    m_n = 0; m_disp = 8'h00; m_pend = 8'h00; m_pv = 0;
    e_seg = 7'h00; e_sel = 2'b00; e_fd = 1'b0;
  endtask

  task automatic model_edge(input logic e, input logic l, input logic [7:0] b);
    int  p;
    bit  bnd;
    bnd = 0;
    if (e) begin
      p = m_n % FRAME;
      if (p % RD == 0) begin
        e_seg = 7'h00; e_sel = 2'b00;
      end else begin
        e_sel = 2'(1 << (p / RD));
        e_seg = ref_seg(m_disp, p / RD);
      end
      bnd  = (p == FRAME - 1);
      e_fd = bnd;
      m_n++;
    end else begin
      e_fd = 1'b0;
    end
    if (l) begin m_pend = b; m_pv = 1; end
    if (bnd) begin
      if (l) begin m_disp = b; m_pv = 0; end
      else if (m_pv) begin m_disp = m_pend; m_pv = 0; end
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic e, input logic l, input logic [7:0] b);
    ena = e; load = l; bcd_in = b;
    @(posedge clk);
    model_edge(e, l, b);
    #1;
    $display("step n=%0d ena=%0b load=%0b bcd=%02h seg=%02h sel=%02b fd=%0b",
             m_n, e, l, b, seg, digit_sel, frame_done);
    chk("model_seg", {1'b0, seg}, {1'b0, e_seg});
    chk("model_sel", {6'b0, digit_sel}, {6'b0, e_sel});
    chk("model_fd", {7'b0, frame_done}, {7'b0, e_fd});
  endtask

  task automatic frame_capture(output logic [6:0] s0, output logic [6:0] s1);
    s0 = 7'bx; s1 = 7'bx;
    while (m_n % FRAME != 0) step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < FRAME; i++) begin
      step(1'b1, 1'b0, 8'h00);
      if (digit_sel == 2'b01) s0 = seg;
      if (digit_sel == 2'b10) s1 = seg;
    end
  endtask

  typedef struct {
    logic       e;
    logic       l;
    logic [7:0] b;
    logic [6:0] seg;
    logic [1:0] sel;
    logic       fd;
  } vec_t;

  vec_t tbl [24];

  initial begin
    logic [6:0] s0, s1;

    // Frame 1: reset value 0, digit 1 blanked. Frame 2: load 47 mid-frame, not yet shown.
    // Frame 3: 47 displayed.
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 7'h00, 2'b00, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 7'h3F, 2'b01, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 8'h00, 7'h3F, 2'b01, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 8'h00, 7'h3F, 2'b01, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 8'h00, 7'h00, 2'b00, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 8'h00, 7'h00, 2'b10, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 8'h00, 7'h00, 2'b10, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 8'h00, 7'h00, 2'b10, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 8'h00, 7'h00, 2'b00, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 8'h47, 7'h3F, 2'b01, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 8'h00, 7'h3F, 2'b01, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 8'h00, 7'h3F, 2'b01, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 8'h00, 7'h00, 2'b00, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 8'h00, 7'h00, 2'b10, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 8'h00, 7'h00, 2'b10, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 8'h00, 7'h00, 2'b10, 1'b1};
    tbl[16] = '{1'b1, 1'b0, 8'h00, 7'h00, 2'b00, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 8'h00, 7'h07, 2'b01, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 8'h00, 7'h07, 2'b01, 1'b0};
    tbl[19] = '{1'b1, 1'b0, 8'h00, 7'h07, 2'b01, 1'b0};
    tbl[20] = '{1'b1, 1'b0, 8'h00, 7'h00, 2'b00, 1'b0};
    tbl[21] = '{1'b1, 1'b0, 8'h00, 7'h66, 2'b10, 1'b0};
    tbl[22] = '{1'b1, 1'b0, 8'h00, 7'h66, 2'b10, 1'b0};
    tbl[23] = '{1'b1, 1'b0, 8'h00, 7'h66, 2'b10, 1'b1};

    rst_n = 1'b0; ena = 1'b0; load = 1'b0; bcd_in = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_seg", {1'b0, seg}, 8'h00);
    chk("reset_sel", {6'b0, digit_sel}, 8'h00);
    chk("reset_fd", {7'b0, frame_done}, 8'h00);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      step(tbl[i].e, tbl[i].l, tbl[i].b);
      chk($sformatf("tbl%0d_seg", i), {1'b0, seg}, {1'b0, tbl[i].seg});
      chk($sformatf("tbl%0d_sel", i), {6'b0, digit_sel}, {6'b0, tbl[i].sel});
      chk($sformatf("tbl%0d_fd", i), {7'b0, frame_done}, {7'b0, tbl[i].fd});
    end

    // Load coincident with the frame boundary bypasses to the display.
    while (m_n % FRAME != FRAME - 1) step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h05);
    chk("bypass_fd", {7'b0, frame_done}, 8'h01);
    frame_capture(s0, s1);
    chk("bypass_d0", {1'b0, s0}, 8'h6D);
    chk("bypass_d1", {1'b0, s1}, 8'h00);

    // Freeze mid-slot for 10 clocks, then resume.
    while (m_n % FRAME != 2) step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00);
    chk("freeze_seg", {1'b0, seg}, 8'h6D);
    chk("freeze_sel", {6'b0, digit_sel}, 8'h01);
    step(1'b1, 1'b0, 8'h00);
    chk("resume_seg", {1'b0, seg}, 8'h6D);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    chk("resume_dead_sel", {6'b0, digit_sel}, 8'h00);

    // Nonzero upper digit keeps a zero units digit visible; 10 decodes as E.
    step(1'b1, 1'b1, 8'hA0);
    frame_capture(s0, s1);
    chk("a0_d0", {1'b0, s0}, 8'h3F);
    chk("a0_d1", {1'b0, s1}, 8'h79);

    // Asynchronous reset mid-slot discards a pending load.
    while (m_n % FRAME != 1) step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h99);
    step(1'b1, 1'b0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_seg", {1'b0, seg}, 8'h00);
    chk("async_rst_sel", {6'b0, digit_sel}, 8'h00);
    chk("async_rst_fd", {7'b0, frame_done}, 8'h00);
    ena = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    frame_capture(s0, s1);
    chk("post_rst_d0", {1'b0, s0}, 8'h3F);
    chk("post_rst_d1", {1'b0, s1}, 8'h00);
    frame_capture(s0, s1);
    chk("post_rst_d0_again", {1'b0, s0}, 8'h3F);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic       e, l;
      logic [7:0] b;
      e = ($urandom_range(0, 9) < 8);
      l = ($urandom_range(0, 9) == 0);
      b = 8'($urandom);
      step(e, l, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
